// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared constants, sequencer state encoding and twiddle select
//            for the 64-point radix-2 DIF FFT control path.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N      = 64;
  localparam int FFT_LOG2N  = 6;
  localparam int FFT_STAGES = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // k = (pos << stage) mod 32, re-packed as {fine W0..W7, coarse none/W8/W16/W24}
  function automatic logic [4:0] twiddle_sel(input logic [2:0] stage, input logic [4:0] pos);
    logic [4:0] k;
    k = pos << stage;
    return {k[2:0], k[4:3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_delay.sv
`default_nettype none
// ============================================================================
// Module   : fft_addr_delay
// Brief    : Valid + payload shift register with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module fft_addr_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_sequencer
// Brief    : Walks the in-place FFT data RAM through 6 stages x 32 butterflies,
//            aligning twiddle selects with read data and writing results back.
// Revision : 1.0 - initial release
// ============================================================================
module butterfly_sequencer
  import fft_pkg::*;
#(
  parameter int RAM_RD_LAT = 1,
  parameter int BF_LATENCY = 3,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [4:0]        bfpcontrol,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int                c_wr_lat     = RAM_RD_LAT + BF_LATENCY;
  localparam logic [2:0]        c_last_stage = 3'(FFT_STAGES - 1);
  localparam logic [4:0]        c_last_bf    = 5'(FFT_N / 2 - 1);
  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(FFT_N - 1);
  localparam logic [ADDR_W-1:0] c_half       = ADDR_W'(FFT_N / 2);

  seq_state_t            r_state, w_state_nxt;
  logic [2:0]            r_stage;
  logic [4:0]            r_bf;
  logic [ADDR_W-1:0]     w_j, w_span, w_mask, w_addr_a, w_addr_b;
  logic [4:0]            w_pos;
  logic                  w_rd;
  logic                  w_bfp_vld;
  logic [4:0]            w_bfp;
  logic                  w_wr_vld;
  logic [2*ADDR_W-1:0]   w_wr_addr;
  logic                  w_stage_end;

  // addr_a = grp*2*span + pos: the group bits move up one place, pos stays put
  assign w_j      = ADDR_W'(r_bf);
  assign w_span   = c_half >> r_stage;
  assign w_mask   = w_span - ADDR_W'(1);
  assign w_pos    = r_bf & w_mask[4:0];
  assign w_addr_a = ((w_j & ~w_mask) << 1) | (w_j & w_mask);
  assign w_addr_b = w_addr_a + w_span;
  assign w_rd     = (r_state == ST_ISSUE);

  // addr_b = 63 belongs to the last butterfly of every stage
  assign w_stage_end = w_wr_vld && (w_wr_addr[ADDR_W-1:0] == c_last_addr);

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    stage       = r_stage;
    rd_en       = w_rd;
    rd_addr_a   = w_rd ? w_addr_a : '0;
    rd_addr_b   = w_rd ? w_addr_b : '0;
    bfpcontrol  = w_bfp_vld ? w_bfp : '0;
    wr_en       = w_wr_vld;
    wr_addr_a   = w_wr_vld ? w_wr_addr[2*ADDR_W-1:ADDR_W] : '0;
    wr_addr_b   = w_wr_vld ? w_wr_addr[ADDR_W-1:0] : '0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (r_bf == c_last_bf) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_stage_end) w_state_nxt = (r_stage == c_last_stage) ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ISSUE) r_bf <= r_bf + 5'd1;
      if (r_state == ST_DRAIN && w_stage_end && r_stage != c_last_stage) r_stage <= r_stage + 3'd1;
      if (r_state == ST_DONE) r_stage <= '0;
    end
  end

  fft_addr_delay #(.DEPTH(RAM_RD_LAT), .W(5)) u_bfp_dly (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_rd),
    .i_data  (twiddle_sel(r_stage, w_pos)),
    .o_valid (w_bfp_vld),
    .o_data  (w_bfp)
  );

  fft_addr_delay #(.DEPTH(c_wr_lat), .W(2*ADDR_W)) u_wr_dly (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_rd),
    .i_data  ({w_addr_a, w_addr_b}),
    .o_valid (w_wr_vld),
    .o_data  (w_wr_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_butterfly_sequencer
// Brief    : Scoreboard bench for butterfly_sequencer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_butterfly_sequencer;

  localparam int RD_LAT = 1;
  localparam int LAT    = 4;
  localparam int PERIOD = 32 + LAT;

  typedef struct {int cyc; int a; int b;} acc_t;
  typedef struct {int cyc; int v;} bfp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [5:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [4:0] bfpcontrol;

  butterfly_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .stage      (stage),
    .rd_en      (rd_en),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .bfpcontrol (bfpcontrol),
    .wr_en      (wr_en),
    .wr_addr_a  (wr_addr_a),
    .wr_addr_b  (wr_addr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
  endtask

  acc_t rd_q[$];
  acc_t wr_q[$];
  bfp_t bfp_q[$];
  int   c0 = -1000;
  int   done_c = -1;
  bit   run_on = 1'b0;
  int   n_rd = 0, n_wr = 0, n_done = 0;
  int   rd_cnt[64];
  int   wr_cnt[64];

  task automatic push_run(input int t0);
    int span, grp, pos, a, b, k, t;
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < 32; j++) begin
        span = 32 >> s;
        grp  = j >> (5 - s);
        pos  = j % span;
        a    = grp * 2 * span + pos;
        b    = a + span;
        k    = (pos * (1 << s)) % 32;
        t    = t0 + 1 + s * PERIOD + j;
        rd_q.push_back('{t, a, b});
        bfp_q.push_back('{t + RD_LAT, (k % 8) * 4 + k / 8});
        wr_q.push_back('{t + LAT, a, b});
      end
    end
    done_c = t0 + 6 * PERIOD + 1;
  endtask

  always @(negedge clk) begin
    acc_t r;
    bfp_t f;
    int   e_bfp;
    bit   e_rd, e_wr;
    if (!reset) begin
      check("rst_rd_en", rd_en, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bfp", bfpcontrol, 0);
      check("rst_stage", stage, 0);
      check("rst_rd_addr_b", rd_addr_b, 0);
      check("rst_wr_addr_b", wr_addr_b, 0);
      rd_q.delete();
      wr_q.delete();
      bfp_q.delete();
      run_on = 1'b0;
      for (int i = 0; i < 64; i++) begin
        rd_cnt[i] = 0;
        wr_cnt[i] = 0;
      end
    end else begin
      e_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
      check("rd_en", rd_en, e_rd);
      if (e_rd) begin
        r = rd_q.pop_front();
        check("rd_addr_a", rd_addr_a, r.a);
        check("rd_addr_b", rd_addr_b, r.b);
      end
      if (rd_en) begin
        check("hazard_a", rd_cnt[rd_addr_a] - wr_cnt[rd_addr_a], 0);
        check("hazard_b", rd_cnt[rd_addr_b] - wr_cnt[rd_addr_b], 0);
        rd_cnt[rd_addr_a]++;
        rd_cnt[rd_addr_b]++;
        n_rd++;
      end
      e_bfp = 0;
      if ((bfp_q.size() > 0) && (bfp_q[0].cyc == cyc)) begin
        f = bfp_q.pop_front();
        e_bfp = f.v;
      end
      check("bfpcontrol", bfpcontrol, e_bfp);
      e_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      check("wr_en", wr_en, e_wr);
      if (e_wr) begin
        r = wr_q.pop_front();
        check("wr_addr_a", wr_addr_a, r.a);
        check("wr_addr_b", wr_addr_b, r.b);
      end
      if (wr_en) begin
        wr_cnt[wr_addr_a]++;
        wr_cnt[wr_addr_b]++;
        n_wr++;
      end
      check("busy", busy, run_on && cyc > c0 && cyc <= done_c);
      check("done", done, run_on && cyc == done_c);
      if (run_on && cyc > c0 && cyc < done_c) check("stage", stage, (cyc - c0 - 1) / PERIOD);
      if (run_on && cyc == c0 + 1) check("first_rd_b", rd_addr_b, 32);
      if (run_on && cyc == c0 + 3) check("second_bfp", bfpcontrol, 5'b00100);
      if (run_on && cyc == c0 + 5) check("first_wr_b", wr_addr_b, 32);
      if (run_on && cyc == done_c) begin
        check("rd_count", n_rd, 192);
        check("wr_count", n_wr, 192);
        n_done++;
      end
      if (start && !(run_on && cyc <= done_c)) begin
        c0     = cyc;
        run_on = 1'b1;
        n_rd   = 0;
        n_wr   = 0;
        push_run(cyc);
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    wait_to(3);   reset = 1'b1;
    // single run, with stray start pulses while busy
    wait_to(10);  start = 1'b1;
    wait_to(11);  start = 1'b0;
    wait_to(50);  start = 1'b1;
    wait_to(51);  start = 1'b0;
    wait_to(110); start = 1'b1;
    wait_to(111); start = 1'b0;
    // start held high across two back-to-back runs
    wait_to(240); start = 1'b1;
    wait_to(461); start = 1'b0;
    // reset during stage 3, then a clean run
    wait_to(700); start = 1'b1;
    wait_to(701); start = 1'b0;
    wait_to(820); reset = 1'b0;
    wait_to(823); reset = 1'b1;
    wait_to(830); start = 1'b1;
    wait_to(831); start = 1'b0;
    wait_to(1060);
    check("runs_done", n_done, 4);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("bfp_q_empty", bfp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
